l2_plru_replace: RTL

Per-set tree pseudo-LRU replacement tracker for the 4-way L2 cache. Sits directly downstream of the L2 hit detector: consumes its one-hot hit vector and the way valid bits for the indexed set, and keeps the PLRU state current on every hit. On a miss it produces a registered victim way for the L2 miss/fill controller. The fill controller reports completed line fills back so the filled way becomes most-recently-used.

---
 rtl/l2_plru_replace.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/l2_plru_replace.sv
// l2_plru_replace
//
// Per-set tree pseudo-LRU replacement tracker for the 4-way L2 cache.
// Every hit and every completed fill makes the touched way most-recently-used
// in its set. A lookup that misses produces a registered victim one cycle
// later. The victim is computed from the set's PLRU bits as they were before
// any update in that cycle.
//
// Each set holds three PLRU bits {b0,b1,b2}, stored as bit2=b0, bit1=b1,
// bit0=b2:
//   b0 : 0 = victim in the left pair (ways 0/1), 1 = victim in the right pair (ways 2/3)
//   b1 : victim within the left pair (0 = way0, 1 = way1)
//   b2 : victim within the right pair (0 = way2, 1 = way3)
//
// Optional feature, macro L2_INVALID_FIRST_EN:
//   When defined, a miss in a set that has an invalid way picks the
//   lowest-index invalid way. When undefined, valid0..valid3 are unused.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   lookup_valid/_index   tag lookup presented this cycle, and its set index
//   hit0..hit3            one-hot hit vector (several set = lowest way wins)
//   valid0..valid3        valid bits of the indexed set's ways
//   fill_valid/_index/_way  completed line fill (set and way)
//   victim_valid          one-cycle pulse, one cycle after a missing lookup
//   victim_way            encoded victim way (holds while victim_valid=0)
//   victim_onehot         one-hot form of victim_way
module l2_plru_replace #(
    parameter int INDEX_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic               hit0,
    input  logic               hit1,
    input  logic               hit2,
    input  logic               hit3,
    input  logic               valid0,
    input  logic               valid1,
    input  logic               valid2,
    input  logic               valid3,
    input  logic               fill_valid,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [1:0]         fill_way,
    output logic               victim_valid,
    output logic [1:0]         victim_way,
    output logic [3:0]         victim_onehot
);

    localparam int NSETS = 1 << INDEX_W;

    // All sets in one packed vector so that reset clears every set in a
    // single process, with no dependence on clk.
    logic [NSETS*3-1:0] plru_reg;
    logic [NSETS*3-1:0] plru_next;
    logic [2:0]         set_state [NSETS];

    logic               victim_valid_reg;
    logic [1:0]         victim_way_reg;
    logic [3:0]         victim_onehot_reg;

    logic [3:0]         hit_vec;
    logic               any_hit;
    logic [1:0]         hit_way;
    logic               miss;
    logic [2:0]         cur_plru;
    logic [1:0]         victim_way_next;

    // Access update: make way w the most-recently-used way. Bits that the
    // update does not touch keep their value.
    function automatic logic [2:0] touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] t;
        t = p;
        case (w)
            2'd0: t = {1'b1, 1'b1, p[0]};
            2'd1: t = {1'b1, 1'b0, p[0]};
            2'd2: t = {1'b0, p[1], 1'b1};
            default: t = {1'b0, p[1], 1'b0};
        endcase
        return t;
    endfunction

    assign hit_vec = {hit3, hit2, hit1, hit0};
    assign any_hit = |hit_vec;
    assign miss    = lookup_valid && !any_hit;

    // Several hits resolve to the lowest-index way, matching the priority
    // of the hit detector.
    always_comb begin
        hit_way = 2'd3;
        if (hit_vec[0])
            hit_way = 2'd0;
        else if (hit_vec[1])
            hit_way = 2'd1;
        else if (hit_vec[2])
            hit_way = 2'd2;
    end

    generate
        for (genvar gi = 0; gi < NSETS; gi++) begin : g_set
            logic [2:0] set_next;

            assign set_state[gi] = plru_reg[gi*3 +: 3];

            // The hit update is applied first and the fill update second,
            // so the fill wins on any bit that both of them touch.
            always_comb begin
                set_next = plru_reg[gi*3 +: 3];
                if (lookup_valid && any_hit && lookup_index == INDEX_W'(gi))
                    set_next = touch(set_next, hit_way);
                if (fill_valid && fill_index == INDEX_W'(gi))
                    set_next = touch(set_next, fill_way);
            end

            assign plru_next[gi*3 +: 3] = set_next;
        end
    endgenerate

    // Victim selection reads the state before this cycle's update.
    assign cur_plru = set_state[lookup_index];

`ifdef L2_INVALID_FIRST_EN
    always_comb begin
        victim_way_next = cur_plru[2] ? (cur_plru[0] ? 2'd3 : 2'd2)
                                      : (cur_plru[1] ? 2'd1 : 2'd0);
        if (!valid0)
            victim_way_next = 2'd0;
        else if (!valid1)
            victim_way_next = 2'd1;
        else if (!valid2)
            victim_way_next = 2'd2;
        else if (!valid3)
            victim_way_next = 2'd3;
    end
`else
    // The valid bits only matter when the invalid-first policy is built in.
    logic unused_valid;
    assign unused_valid = &{1'b0, valid0, valid1, valid2, valid3};

    always_comb begin
        victim_way_next = cur_plru[2] ? (cur_plru[0] ? 2'd3 : 2'd2)
                                      : (cur_plru[1] ? 2'd1 : 2'd0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plru_reg          <= '0;
            victim_valid_reg  <= 1'b0;
            victim_way_reg    <= 2'd0;
            victim_onehot_reg <= 4'b0000;
        end else begin
            plru_reg         <= plru_next;
            victim_valid_reg <= miss;
            // The victim fields only change when a miss occurs, so they
            // hold their last value between pulses.
            if (miss) begin
                victim_way_reg    <= victim_way_next;
                victim_onehot_reg <= 4'b0001 << victim_way_next;
            end
        end
    end

    assign victim_valid  = victim_valid_reg;
    assign victim_way    = victim_way_reg;
    assign victim_onehot = victim_onehot_reg;

endmodule
